// File: rtl/bram_banked_memory_if.sv
// Request/response bundle for one port of bram_banked_memory.
// The master drives requests; the slave (memory) returns ready and read data.
interface bram_banked_memory_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned BYTES      = 4
);
    logic                    valid;
    logic                    ready;
    logic                    write;
    logic [BYTES-1:0]        wmask;
    logic [8*BYTES-1:0]      wdata;
    logic                    wgrubby;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [8*BYTES-1:0]      rdata;
    logic                    rgrubby;
    logic                    rvalid;

    modport master (
        output valid, write, wmask, wdata, wgrubby, addr,
        input  ready, rdata, rgrubby, rvalid
    );

    modport slave (
        input  valid, write, wmask, wdata, wgrubby, addr,
        output ready, rdata, rgrubby, rvalid
    );
endinterface

// File: rtl/bram_banked_memory.sv
// Byte-banked single-ported memory shared by two request ports.
// Port A has fixed priority; port B is forced through after STARVE_LIMIT waits.
module bram_banked_memory #(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned BYTES        = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned GRUBBY       = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rstn,
    bram_banked_memory_if.slave a,
    bram_banked_memory_if.slave b
);
    localparam int unsigned DW    = 8 * BYTES;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [CW-1:0]         r_starve;
    logic                  w_force;
    logic                  w_a_acc;
    logic                  w_b_acc;
    logic                  w_acc;
    logic                  w_wr_en;
    logic                  w_write;
    logic                  w_wgrubby;
    logic [BYTES-1:0]      w_wmask;
    logic [DW-1:0]         w_wdata;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DW-1:0]         w_rword;
    logic                  w_rtag;
    logic [1:0]            w_rd_acc;

    logic [1:0][DW-1:0]    r_s1_data;
    logic [1:0]            r_s1_tag;
    logic [1:0]            r_s1_vld;
    logic [1:0][DW-1:0]    w_out_data;
    logic [1:0]            w_out_tag;
    logic [1:0]            w_out_vld;

    // B wins only when its wait counter has hit the limit; otherwise A has priority
    assign w_force = (STARVE_LIMIT != 0) && b.valid && (r_starve == STARVE_MAX);
    assign a.ready = !w_force;
    assign b.ready = b.valid && (w_force || !a.valid);
    assign w_a_acc = a.valid && a.ready;
    assign w_b_acc = b.valid && b.ready;
    assign w_acc   = w_a_acc || w_b_acc;

    always_comb begin
        w_write   = a.write;
        w_wmask   = a.wmask;
        w_wdata   = a.wdata;
        w_wgrubby = a.wgrubby;
        w_addr    = a.addr;
        if (w_b_acc) begin
            w_write   = b.write;
            w_wmask   = b.wmask;
            w_wdata   = b.wdata;
            w_wgrubby = b.wgrubby;
            w_addr    = b.addr;
        end
    end

    assign w_wr_en  = w_acc && w_write;
    assign w_rd_acc = {w_b_acc && !b.write, w_a_acc && !a.write};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve <= '0;
        end else if (!b.valid || w_b_acc) begin
            r_starve <= '0;
        end else if (r_starve != STARVE_MAX) begin
            r_starve <= r_starve + CW'(1);
        end
    end

    for (genvar g = 0; g < BYTES; g++) begin : g_lane
        logic [7:0] r_lane [DEPTH];

        always_ff @(posedge clk) begin
            if (w_wr_en && w_wmask[g]) begin
                r_lane[w_addr] <= w_wdata[g*8 +: 8];
            end
        end

        assign w_rword[g*8 +: 8] = r_lane[w_addr];
    end

    if (GRUBBY != 0) begin : g_tag
        logic r_tag [DEPTH];

        // A fully masked write leaves the tag alone as well
        always_ff @(posedge clk) begin
            if (w_wr_en && (|w_wmask)) begin
                r_tag[w_addr] <= w_wgrubby;
            end
        end

        assign w_rtag = r_tag[w_addr];
    end else begin : g_no_tag
        logic w_unused_tag;
        assign w_unused_tag = w_wgrubby;
        assign w_rtag       = 1'b0;
    end

    // Per-port read registers hold their value until that port's next read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_data <= '0;
            r_s1_tag  <= '0;
            r_s1_vld  <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            for (int p = 0; p < 2; p++) begin
                if (w_rd_acc[p]) begin
                    r_s1_data[p] <= w_rword;
                    r_s1_tag[p]  <= w_rtag;
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_rl2
        logic [1:0][DW-1:0] r_s2_data;
        logic [1:0]         r_s2_tag;
        logic [1:0]         r_s2_vld;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_s2_data <= '0;
                r_s2_tag  <= '0;
                r_s2_vld  <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                for (int p = 0; p < 2; p++) begin
                    if (r_s1_vld[p]) begin
                        r_s2_data[p] <= r_s1_data[p];
                        r_s2_tag[p]  <= r_s1_tag[p];
                    end
                end
            end
        end

        assign w_out_data = r_s2_data;
        assign w_out_tag  = r_s2_tag;
        assign w_out_vld  = r_s2_vld;
    end else begin : g_rl1
        assign w_out_data = r_s1_data;
        assign w_out_tag  = r_s1_tag;
        assign w_out_vld  = r_s1_vld;
    end

    assign a.rdata   = w_out_data[0];
    assign a.rgrubby = w_out_tag[0];
    assign a.rvalid  = w_out_vld[0];
    assign b.rdata   = w_out_data[1];
    assign b.rgrubby = w_out_tag[1];
    assign b.rvalid  = w_out_vld[1];
endmodule
